// File: rtl/except_ctl_pkg.sv
// -----------------------------------------------------------------------------
// except_ctl_pkg
//   Shared constants for the precise-exception / interrupt control unit.
//   - Exception cause codes carried down the tracking pipeline and reported
//     to coproc0 on o_except_code.
//   - Vector layout of the interrupt vector table (16 bytes per vector,
//     table occupies the low 10 address bits below the COP0 IVT base).
//   - Encodings of the redirect state machine.
// -----------------------------------------------------------------------------
package except_ctl_pkg;

  // Exception cause codes. The numeric order is also the reporting order the
  // rest of the core expects, so do not renumber.
  localparam int unsigned EXC_NONE    = 0;
  localparam int unsigned EXC_DECODE  = 1;
  localparam int unsigned EXC_SYSCALL = 2;
  localparam int unsigned EXC_BREAK   = 3;
  localparam int unsigned EXC_OVF     = 4;
  localparam int unsigned EXC_BUSERR  = 5;
  localparam int unsigned EXC_IRQ     = 6;

  // Each vector is 16 bytes, so the code is shifted left by 4 to form the
  // offset inside the table.
  localparam int unsigned VEC_SHIFT     = 4;
  // Number of low address bits spanned by the vector table; the COP0 base
  // supplies everything above this.
  localparam int unsigned IVT_SPAN_BITS = 10;

  // Redirect state machine encodings.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

endpackage

// File: rtl/except_irq_sync.sv
// -----------------------------------------------------------------------------
// except_irq_sync
//   Two-flop synchronizer for the external interrupt request level. Only
//   instantiated by except_ctl when CPU_EXCEPT_IRQ_SYNC_EN is defined; adds two
//   cycles of latency between i_async and o_sync.
//
// Ports
//   clk      in  core clock
//   rst      in  synchronous active-high reset (both flops cleared to 0)
//   i_async  in  asynchronous level input
//   o_sync   out synchronized level
// -----------------------------------------------------------------------------
module except_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // First stage may go metastable; only the second stage is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/except_ctl.sv
// -----------------------------------------------------------------------------
// except_ctl
//   Precise-exception and interrupt control unit. Tracks exception sources
//   from decode (p1) through execute (p2) to writeback (p3). When the p3
//   instruction carries a pending exception, a bus error, or is interrupted,
//   the unit raises o_except_start plus all nullify strobes for one cycle,
//   then requests a fetch redirect to the interrupt vector table and drains
//   the decode stage once the redirect has been accepted.
//
// Configuration
//   CPU_EXCEPT_IRQ_SYNC_EN  when defined, i_irq passes through a 2-flop
//                           synchronizer (except_irq_sync); otherwise i_irq
//                           must already be synchronous to clk.
//
// Ports
//   clk, rst             core clock, synchronous active-high reset
//   i_core_stall         freezes tracking and suppresses any take
//   i_pc_p1, i_dly_slt_p1, i_valid_p1   decode-stage instruction info
//   i_decode_error, i_syscall_p1, i_break_p1   decode-stage sources
//   i_ovf_p2             execute-stage overflow
//   i_bus_err_p3         memory-stage data bus error (for the p3 instruction)
//   i_irq, i_cop0_ie     interrupt request level and COP0 enable
//   i_cop0_ivtbase       IVT base (upper ADDR_WIDTH-10 bits)
//   i_fetch_ack          fetch accepted the redirect
//   o_except_start       exception taken this cycle
//   o_except_dly_slt     faulting instruction sits in a delay slot
//   o_except_raddr       faulting PC
//   o_except_raddr_dly   faulting PC minus 4 (branch address)
//   o_nullify_*          per-stage kill strobes
//   o_fetch_redirect     redirect request, held until i_fetch_ack
//   o_fetch_addr         redirect target inside the vector table
//   o_except_code        cause code of the last taken exception
// -----------------------------------------------------------------------------
module except_ctl
  import except_ctl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CODE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_core_stall,
  input  logic [ADDR_WIDTH-1:0]  i_pc_p1,
  input  logic                   i_dly_slt_p1,
  input  logic                   i_valid_p1,
  input  logic                   i_decode_error,
  input  logic                   i_syscall_p1,
  input  logic                   i_break_p1,
  input  logic                   i_ovf_p2,
  input  logic                   i_bus_err_p3,
  input  logic                   i_irq,
  input  logic                   i_cop0_ie,
  input  logic [ADDR_WIDTH-11:0] i_cop0_ivtbase,
  input  logic                   i_fetch_ack,
  output logic                   o_except_start,
  output logic                   o_except_dly_slt,
  output logic [ADDR_WIDTH-1:0]  o_except_raddr,
  output logic [ADDR_WIDTH-1:0]  o_except_raddr_dly,
  output logic                   o_nullify_decode,
  output logic                   o_nullify_execute,
  output logic                   o_nullify_mem,
  output logic                   o_nullify_wb,
  output logic                   o_fetch_redirect,
  output logic [ADDR_WIDTH-1:0]  o_fetch_addr,
  output logic [CODE_WIDTH-1:0]  o_except_code
);

  // One tracking slot per pipeline stage boundary.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  dly_slt;
    logic [CODE_WIDTH-1:0] code;
    logic                  pend;
  } trk_t;

  trk_t                   r_p2;
  trk_t                   r_p3;
  trk_t                   w_p2_next;
  trk_t                   w_p3_next;

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [ADDR_WIDTH-11:0] r_ivtbase;
  logic [CODE_WIDTH-1:0]  r_code;

  logic                   w_irq;
  logic                   w_bus_err;
  logic                   w_irq_req;
  logic                   w_take;
  logic [CODE_WIDTH-1:0]  w_take_code;

  // ---------------------------------------------------------------------------
  // Interrupt request conditioning
  // ---------------------------------------------------------------------------
`ifdef CPU_EXCEPT_IRQ_SYNC_EN
  except_irq_sync u_irq_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_irq),
    .o_sync  (w_irq)
  );
`else
  assign w_irq = i_irq;
`endif

  // ---------------------------------------------------------------------------
  // Next values of the tracking slots
  // ---------------------------------------------------------------------------
  // Decode-stage sources, highest priority first. A bubble carries nothing.
  always_comb begin
    w_p2_next = '0;
    if (i_valid_p1) begin
      w_p2_next.valid   = 1'b1;
      w_p2_next.pc      = i_pc_p1;
      w_p2_next.dly_slt = i_dly_slt_p1;
      if (i_decode_error) begin
        w_p2_next.pend = 1'b1;
        w_p2_next.code = CODE_WIDTH'(EXC_DECODE);
      end else if (i_syscall_p1) begin
        w_p2_next.pend = 1'b1;
        w_p2_next.code = CODE_WIDTH'(EXC_SYSCALL);
      end else if (i_break_p1) begin
        w_p2_next.pend = 1'b1;
        w_p2_next.code = CODE_WIDTH'(EXC_BREAK);
      end
    end
  end

  // An overflow only matters when the instruction has no older-stage cause;
  // the decode-stage cause happened first in program order and wins.
  always_comb begin
    w_p3_next = r_p2;
    if (r_p2.valid && !r_p2.pend && i_ovf_p2) begin
      w_p3_next.pend = 1'b1;
      w_p3_next.code = CODE_WIDTH'(EXC_OVF);
    end
  end

  // ---------------------------------------------------------------------------
  // Take decision at the writeback boundary
  // ---------------------------------------------------------------------------
  // Bus errors and interrupts are only meaningful against a real instruction.
  assign w_bus_err = r_p3.valid & i_bus_err_p3;
  assign w_irq_req = w_irq & i_cop0_ie & r_p3.valid;

  assign w_take = !rst && (r_state == ST_IDLE) && !i_core_stall &&
                  (r_p3.pend || w_bus_err || w_irq_req);

  // Tracked cause beats a bus error, which beats an interrupt.
  always_comb begin
    if (r_p3.pend) begin
      w_take_code = r_p3.code;
    end else if (w_bus_err) begin
      w_take_code = CODE_WIDTH'(EXC_BUSERR);
    end else begin
      w_take_code = CODE_WIDTH'(EXC_IRQ);
    end
  end

  // ---------------------------------------------------------------------------
  // Tracking registers
  // ---------------------------------------------------------------------------
  // Outside IDLE (and on the take edge itself) the whole pipeline is being
  // nullified, so the slots are flushed rather than loaded; anything arriving
  // then is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p2 <= '0;
      r_p3 <= '0;
    end else if (w_take || (r_state != ST_IDLE)) begin
      r_p2 <= '0;
      r_p3 <= '0;
    end else if (!i_core_stall) begin
      r_p2 <= w_p2_next;
      r_p3 <= w_p3_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_state_next = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (i_fetch_ack) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The decode kill has to land on a cycle where decode actually moves.
        if (!i_core_stall) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // The IVT base is captured at take so a COP0 write racing the redirect
  // cannot move the target.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ivtbase <= '0;
      r_code    <= CODE_WIDTH'(EXC_NONE);
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_ivtbase <= i_cop0_ivtbase;
        r_code    <= w_take_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_except_start     = 1'b0;
    o_except_dly_slt   = 1'b0;
    o_except_raddr     = '0;
    o_except_raddr_dly = '0;
    o_nullify_decode   = 1'b0;
    o_nullify_execute  = 1'b0;
    o_nullify_mem      = 1'b0;
    o_nullify_wb       = 1'b0;
    o_fetch_redirect   = 1'b0;
    o_fetch_addr       = '0;

    if (w_take) begin
      o_except_start     = 1'b1;
      o_except_dly_slt   = r_p3.dly_slt;
      o_except_raddr     = r_p3.pc;
      // Wraps modulo 2^ADDR_WIDTH for a faulting PC of 0.
      o_except_raddr_dly = r_p3.pc - ADDR_WIDTH'(4);
      o_nullify_decode   = 1'b1;
      o_nullify_execute  = 1'b1;
      o_nullify_mem      = 1'b1;
      o_nullify_wb       = 1'b1;
    end

    if (r_state == ST_REDIRECT) begin
      o_fetch_redirect  = 1'b1;
      o_fetch_addr      = {r_ivtbase, {IVT_SPAN_BITS{1'b0}}} |
                          (ADDR_WIDTH'(r_code) << VEC_SHIFT);
      o_nullify_decode  = 1'b1;
      o_nullify_execute = 1'b1;
    end

    if (r_state == ST_DRAIN) begin
      o_nullify_decode = 1'b1;
    end
  end

  // The new code is visible in the take cycle itself and held afterwards.
  assign o_except_code = w_take ? w_take_code : r_code;

endmodule

// File: tb/tb_except_ctl.sv
// -----------------------------------------------------------------------------
// tb_except_ctl
//   Self-checking bench for except_ctl (default build, i_irq used directly).
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. Every expected take is pushed to a scoreboard queue when
//   its stimulus is driven and popped when o_except_start is observed.
// -----------------------------------------------------------------------------
module tb_except_ctl;

  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          i_core_stall;
  logic [AW-1:0] i_pc_p1;
  logic          i_dly_slt_p1;
  logic          i_valid_p1;
  logic          i_decode_error;
  logic          i_syscall_p1;
  logic          i_break_p1;
  logic          i_ovf_p2;
  logic          i_bus_err_p3;
  logic          i_irq;
  logic          i_cop0_ie;
  logic [AW-11:0] i_cop0_ivtbase;
  logic          i_fetch_ack;
  logic          o_except_start;
  logic          o_except_dly_slt;
  logic [AW-1:0] o_except_raddr;
  logic [AW-1:0] o_except_raddr_dly;
  logic          o_nullify_decode;
  logic          o_nullify_execute;
  logic          o_nullify_mem;
  logic          o_nullify_wb;
  logic          o_fetch_redirect;
  logic [AW-1:0] o_fetch_addr;
  logic [CW-1:0] o_except_code;

  except_ctl #(.ADDR_WIDTH(AW), .CODE_WIDTH(CW)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_core_stall       (i_core_stall),
    .i_pc_p1            (i_pc_p1),
    .i_dly_slt_p1       (i_dly_slt_p1),
    .i_valid_p1         (i_valid_p1),
    .i_decode_error     (i_decode_error),
    .i_syscall_p1       (i_syscall_p1),
    .i_break_p1         (i_break_p1),
    .i_ovf_p2           (i_ovf_p2),
    .i_bus_err_p3       (i_bus_err_p3),
    .i_irq              (i_irq),
    .i_cop0_ie          (i_cop0_ie),
    .i_cop0_ivtbase     (i_cop0_ivtbase),
    .i_fetch_ack        (i_fetch_ack),
    .o_except_start     (o_except_start),
    .o_except_dly_slt   (o_except_dly_slt),
    .o_except_raddr     (o_except_raddr),
    .o_except_raddr_dly (o_except_raddr_dly),
    .o_nullify_decode   (o_nullify_decode),
    .o_nullify_execute  (o_nullify_execute),
    .o_nullify_mem      (o_nullify_mem),
    .o_nullify_wb       (o_nullify_wb),
    .o_fetch_redirect   (o_fetch_redirect),
    .o_fetch_addr       (o_fetch_addr),
    .o_except_code      (o_except_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard record for one expected take.
  typedef struct {
    int            code;
    logic [AW-1:0] raddr;
    logic [AW-1:0] raddr_dly;
    bit            dly;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  function automatic logic [AW-1:0] vec_addr(input logic [AW-11:0] base, input int code);
    return {base, 10'b0} | (AW'(code) << 4);
  endfunction

  task automatic push_exp(input int code, input logic [AW-1:0] pc, input bit dly);
    exp_t e;
    e.code      = code;
    e.raddr     = pc;
    e.raddr_dly = pc - 32'd4;
    e.dly       = dly;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every observed take must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && o_except_start) begin
      if (sb.size() == 0) begin
        chk("unexpected_take", 64'(o_except_raddr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("take_code",      64'(o_except_code),      64'(e.code));
        chk("take_raddr",     64'(o_except_raddr),     64'(e.raddr));
        chk("take_raddr_dly", 64'(o_except_raddr_dly), 64'(e.raddr_dly));
        chk("take_dly_slt",   64'(o_except_dly_slt),   64'(e.dly));
        chk("take_nullify",
            64'({o_nullify_decode, o_nullify_execute, o_nullify_mem, o_nullify_wb}), 64'hF);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_pc_p1        = '0;
    i_dly_slt_p1   = 1'b0;
    i_valid_p1     = 1'b0;
    i_decode_error = 1'b0;
    i_syscall_p1   = 1'b0;
    i_break_p1     = 1'b0;
    i_ovf_p2       = 1'b0;
    i_bus_err_p3   = 1'b0;
    i_irq          = 1'b0;
  endtask

  task automatic drive_p1(input logic [AW-1:0] pc, input bit dly, input bit valid,
                          input bit dec, input bit sys, input bit brk);
    i_pc_p1        = pc;
    i_dly_slt_p1   = dly;
    i_valid_p1     = valid;
    i_decode_error = dec;
    i_syscall_p1   = sys;
    i_break_p1     = brk;
  endtask

  // Starts at the drive point of the cycle whose stimulus is already applied.
  // Returns how many cycles later o_except_start was seen and whether the
  // redirect appeared; stimulus is cleared after the first cycle. Ends at the
  // drive point of the second REDIRECT cycle when got is set.
  task automatic wait_redirect(output int start_k, output bit got);
    start_k = -1;
    got     = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_except_start && start_k < 0) start_k = k;
      if (o_fetch_redirect) got = 1'b1;
      step();
      if (k == 0) clear_inputs();
      if (got) break;
    end
  endtask

  // Holds the redirect for extra_cycles, acknowledges it, and checks DRAIN and
  // the return to IDLE. The IVT base input is scrambled to prove it was latched.
  task automatic finish_redirect(input int extra_cycles, input logic [AW-1:0] exp_addr,
                                 input int exp_code);
    i_cop0_ivtbase = ~i_cop0_ivtbase;
    for (int i = 0; i < extra_cycles; i++) begin
      @(negedge clk);
      chk("redirect_held", 64'(o_fetch_redirect), 64'd1);
      chk("redirect_addr", 64'(o_fetch_addr), 64'(exp_addr));
      step();
    end
    i_fetch_ack = 1'b1;
    @(negedge clk);
    chk("redirect_null", 64'({o_nullify_decode, o_nullify_execute, o_nullify_mem, o_nullify_wb}),
        64'hC);
    step();
    i_fetch_ack = 1'b0;
    @(negedge clk);
    chk("drain_state", 64'({o_fetch_redirect, o_nullify_decode, o_nullify_execute}), 64'b010);
    step();
    @(negedge clk);
    chk("idle_after_drain", 64'({o_fetch_redirect, o_nullify_decode}), 64'b00);
    chk("code_held", 64'(o_except_code), 64'(exp_code));
    step();
  endtask

  // Table of single-instruction decode-stage cases.
  typedef struct {
    logic [AW-1:0]  pc;
    bit             dly;
    bit             valid;
    bit             dec;
    bit             sys;
    bit             brk;
    logic [AW-11:0] ivt;
    int             exp_code;  // 0: no take expected
  } vec_t;

  vec_t vt[8];

  initial begin
    int            sk;
    bit            got;
    logic [AW-1:0] pc;

    vt[0] = '{32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 22'h3FFFFF, 1};
    vt[1] = '{32'h0000_2000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 22'h000001, 2};
    vt[2] = '{32'h0000_2004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 22'h012345, 3};
    vt[3] = '{32'h0000_3000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 22'h000ABC, 1};
    vt[4] = '{32'h0000_3004, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 22'h000000, 2};
    vt[5] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 22'h3FFFFF, 3};
    vt[6] = '{32'h0000_4000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 22'h000100, 0};
    vt[7] = '{32'h0000_4004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 22'h000100, 0};

    rst            = 1'b1;
    i_core_stall   = 1'b0;
    i_cop0_ie      = 1'b0;
    i_cop0_ivtbase = 22'h3FFFFF;
    i_fetch_ack    = 1'b0;
    clear_inputs();

    // ---- reset state ----
    step();
    step();
    @(negedge clk);
    chk("reset_start",    64'(o_except_start), 64'd0);
    chk("reset_redirect", 64'(o_fetch_redirect), 64'd0);
    chk("reset_code",     64'(o_except_code), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        64'({o_except_start, o_nullify_decode, o_nullify_execute, o_nullify_mem,
             o_nullify_wb, o_fetch_redirect, o_fetch_addr, o_except_code}), 64'd0);
    step();

    // ---- table-driven decode-stage causes ----
    for (int i = 0; i < 8; i++) begin
      i_cop0_ivtbase = vt[i].ivt;
      drive_p1(vt[i].pc, vt[i].dly, vt[i].valid, vt[i].dec, vt[i].sys, vt[i].brk);
      if (vt[i].exp_code != 0) push_exp(vt[i].exp_code, vt[i].pc, vt[i].dly);
      wait_redirect(sk, got);
      if (vt[i].exp_code != 0) begin
        chk($sformatf("vec%0d_redirect_seen", i), 64'(got), 64'd1);
        chk($sformatf("vec%0d_latency", i), 64'(sk), 64'd2);
        chk($sformatf("vec%0d_fetch_addr", i), 64'(o_fetch_addr),
            64'(vec_addr(vt[i].ivt, vt[i].exp_code)));
        if (got) finish_redirect(1, vec_addr(vt[i].ivt, vt[i].exp_code), vt[i].exp_code);
      end else begin
        chk($sformatf("vec%0d_no_take", i), 64'(got), 64'd0);
      end
    end

    // ---- overflow at p2 with a younger syscall in p1 ----
    i_cop0_ivtbase = 22'h000040;
    drive_p1(32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive_p1(32'h204, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    i_ovf_p2 = 1'b1;
    push_exp(4, 32'h200, 1'b0);
    wait_redirect(sk, got);
    chk("ovf_redirect_seen", 64'(got), 64'd1);
    chk("ovf_latency", 64'(sk), 64'd1);
    if (got) finish_redirect(0, vec_addr(22'h000040, 4), 4);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("ovf_syscall_nullified", 64'(o_except_code), 64'd4);
    step();

    // ---- bus error on a delay-slot instruction at p3 ----
    i_cop0_ivtbase = 22'h000002;
    drive_p1(32'h304, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    step();
    i_bus_err_p3 = 1'b1;
    push_exp(5, 32'h304, 1'b1);
    wait_redirect(sk, got);
    chk("buserr_latency", 64'(sk), 64'd0);
    chk("buserr_fetch_addr", 64'(o_fetch_addr), 64'(vec_addr(22'h000002, 5)));
    if (got) finish_redirect(0, vec_addr(22'h000002, 5), 5);

    // ---- interrupt gated by ie, then taken; redirect held for a while ----
    i_cop0_ivtbase = 22'h0000FF;
    i_irq = 1'b1;
    pc = 32'h500;
    for (int j = 0; j < 6; j++) begin
      drive_p1(pc, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (j >= 2) chk($sformatf("irq_masked_c%0d", j), 64'(o_except_start), 64'd0);
      step();
      pc = pc + 32'd4;
    end
    drive_p1(pc, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    i_cop0_ie = 1'b1;
    push_exp(6, pc - 32'd8, 1'b0);
    wait_redirect(sk, got);
    chk("irq_latency", 64'(sk), 64'd0);
    i_cop0_ie = 1'b0;
    if (got) finish_redirect(2, vec_addr(22'h0000FF, 6), 6);

    // ---- interrupt with no valid instruction at writeback is not taken ----
    i_irq     = 1'b1;
    i_cop0_ie = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("irq_bubble_c%0d", j), 64'(o_except_start), 64'd0);
      step();
    end
    i_irq     = 1'b0;
    i_cop0_ie = 1'b0;

    // ---- stall holding off a pending take for 4 cycles ----
    i_cop0_ivtbase = 22'h000010;
    drive_p1(32'h600, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    clear_inputs();
    step();
    i_core_stall = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d", j),
          64'({o_except_start, o_nullify_decode, o_nullify_wb, o_fetch_redirect}), 64'd0);
      step();
    end
    i_core_stall = 1'b0;
    push_exp(1, 32'h600, 1'b0);
    wait_redirect(sk, got);
    chk("stall_release_latency", 64'(sk), 64'd0);
    if (got) finish_redirect(0, vec_addr(22'h000010, 1), 1);

    // ---- reset while in REDIRECT, then a normal take ----
    i_cop0_ivtbase = 22'h000020;
    drive_p1(32'h700, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push_exp(1, 32'h700, 1'b0);
    wait_redirect(sk, got);
    chk("rstredir_seen", 64'(got), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstredir_outputs",
        64'({o_except_start, o_nullify_decode, o_nullify_execute, o_nullify_mem,
             o_nullify_wb, o_fetch_redirect, o_except_code}), 64'd0);
    step();
    i_cop0_ivtbase = 22'h000021;
    drive_p1(32'h800, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push_exp(1, 32'h800, 1'b0);
    wait_redirect(sk, got);
    chk("post_rst_latency", 64'(sk), 64'd2);
    chk("post_rst_fetch_addr", 64'(o_fetch_addr), 64'(vec_addr(22'h000021, 1)));
    if (got) finish_redirect(0, vec_addr(22'h000021, 1), 1);

    // Every expected take must have been observed.
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard bound on the whole run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/except_ctl.md
Name: except_ctl

Overview:
- Precise-exception and interrupt control unit. Sits beside the pipeline, directly upstream of coproc0.
- Collects per-stage exception sources, including the COP0 decode error, and tracks them down the pipeline to the writeback boundary.
- At that boundary it produces the exception-start and nullify strobes that coproc0 consumes, then redirects fetch to the interrupt vector table.

Parameters:
- ADDR_WIDTH, 32, program-counter width; IVT base is ADDR_WIDTH-10 bits.
- CODE_WIDTH, 4, exception code width; vector offset = code<<4 (16 bytes per vector).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- i_core_stall  in  1  OR of fetch/exec/mem stalls; freezes all tracking registers
- i_pc_p1  in  ADDR_WIDTH  PC of instruction in decode
- i_dly_slt_p1  in  1  decode instruction is in a branch delay slot
- i_valid_p1  in  1  decode holds a real (non-bubble) instruction
- i_decode_error  in  1  decode-stage illegal instruction (main decoder OR COP0 decode error)
- i_syscall_p1  in  1  SYSCALL decoded
- i_break_p1  in  1  BREAK decoded
- i_ovf_p2  in  1  execute-stage arithmetic overflow
- i_bus_err_p3  in  1  memory-stage data bus error
- i_irq  in  1  external interrupt request, level
- i_cop0_ie  in  1  interrupt enable from COP0
- i_cop0_ivtbase  in  ADDR_WIDTH-10  IVT base from COP0
- i_fetch_ack  in  1  fetch accepted redirect
- o_except_start  out  1  exception taken this cycle
- o_except_dly_slt  out  1  faulting instruction is in a delay slot
- o_except_raddr  out  ADDR_WIDTH  PC of faulting instruction
- o_except_raddr_dly  out  ADDR_WIDTH  faulting PC minus 4 (branch address)
- o_nullify_decode, o_nullify_execute, o_nullify_mem, o_nullify_wb  out  1 each  stage kill strobes
- o_fetch_redirect  out  1  redirect request valid
- o_fetch_addr  out  ADDR_WIDTH  redirect target
- o_except_code  out  CODE_WIDTH  code of last taken exception (held)

Behaviour:
- Reset: all outputs 0; FSM = IDLE; all tracking registers cleared.
- Tracking pipeline:
  - Registers p2 and p3 each hold {valid, pc, dly_slt, code, pend}.
  - Advance only when !i_core_stall.
  - Decode-stage priority when loading p2: decode_error(code 1) > syscall(2) > break(3).
  - At the p2->p3 step, an overflow (4) is recorded only if p2 has no pend.
  - A stage's input bubble (valid=0) carries no pend.
- Commit point is the p3 register, i.e. the instruction presently at writeback.
- Exception is taken in IDLE, when !i_core_stall and either condition holds:
  - p3.pend or i_bus_err_p3 (bus_err code 5; it loses only to an existing p3.pend);
  - or i_irq && i_cop0_ie && p3.valid (code 6; lowest priority).
- Cycle of take (single cycle):
  - o_except_start=1; all four nullify=1.
  - raddr=p3.pc; raddr_dly=p3.pc-4 (modulo 2^ADDR_WIDTH).
  - dly_slt=p3.dly_slt; o_except_code updated.
  - p2/p3 cleared next edge.
  - Interrupt return address is the un-executed p3 instruction.
- Stall rule: if i_core_stall, nothing is taken and strobes stay 0; evaluation repeats when the stall drops.
- FSM:
  - IDLE -> REDIRECT on take.
  - REDIRECT: o_fetch_redirect=1; o_fetch_addr={ivtbase, (10-CODE_WIDTH-4)'b0, code, 4'b0}. ivtbase is sampled at take and held. o_nullify_decode=1, o_nullify_execute=1. Stays here until i_fetch_ack. On ack -> DRAIN.
  - DRAIN: o_nullify_decode=1 for exactly one non-stalled cycle, then IDLE.
- No new exception or interrupt is taken outside IDLE; sources arriving then are discarded because the pipeline is nullified.
- Simultaneous events: take and i_fetch_ack together is impossible (ack is only sampled in REDIRECT).
- Reset in REDIRECT/DRAIN returns the FSM to IDLE the next cycle with all strobes 0.

Optional Feature:
- CPU_EXCEPT_IRQ_SYNC_EN defined: i_irq passes through a 2-flop synchronizer (reset 0), adding 2 cycles of interrupt latency.
- Undefined: i_irq is used directly and must be synchronous to clk.

Decomposition:
- Exception codes (NONE=0, DECODE=1, SYSCALL=2, BREAK=3, OVF=4, BUSERR=5, IRQ=6) and the vector shift constant go in cpu_const.vh.
- Sub-module except_irq_sync (2-flop synchronizer, compiled under the macro).

Test Plan:
- Decode error at pc 0x100, ivtbase 0x3FFFFF, no stalls → o_except_start for one cycle exactly 2 cycles after p1. raddr=0x100, code 1, o_fetch_addr=0xFFFFFC10.
- Overflow at p2 pc 0x200 while a younger syscall sits in p1 → only overflow is taken (code 4, raddr 0x200); the syscall is nullified.
- Bus error at p3 in delay slot pc 0x304 → dly_slt=1, raddr_dly=0x300, code 5.
- i_irq=1 with i_cop0_ie=0 → no take. Raise ie → take on the next valid p3 with code 6; the redirect is held until i_fetch_ack after 3 cycles.
- i_core_stall high for 4 cycles with a pending p3 exception → no strobes during the stall; the take occurs on the first unstalled cycle.
- rst asserted in REDIRECT → all outputs 0 next cycle, FSM IDLE; a later decode error is taken normally.
